// File: rtl/hdlc_ctrl_pkg.sv
// Shared types and default constants for the HDLC frame sequencer.
// States, register map, control bit positions and frame limits.
package hdlc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_TX_LOAD,
      S_TX_START,
      S_TX_WAIT,
      S_RX_LEN,
      S_RX_LEN_WAIT,
      S_RX_RD,
      S_RX_RD_WAIT,
      S_RX_OUT,
      S_RX_DROP
   } state_t;

   localparam logic [2:0] DEF_ADDR_TX_SC  = 3'd0;
   localparam logic [2:0] DEF_ADDR_TX_BUF = 3'd1;
   localparam logic [2:0] DEF_ADDR_RX_SC  = 3'd2;
   localparam logic [2:0] DEF_ADDR_RX_BUF = 3'd3;
   localparam logic [2:0] DEF_ADDR_RX_LEN = 3'd4;

   localparam int DEF_TX_EN_BIT   = 1;
   localparam int DEF_RX_DROP_BIT = 1;
   localparam int DEF_MAX_FRAME   = 126;
   localparam int DEF_RD_LAT      = 1;

endpackage

// File: rtl/hdlc_frame_ctrl.sv
// Frame sequencer sharing the HDLC core register bus between Tx and Rx.
// Define HDLC_FRAME_CTRL_STATS_EN to add Tx/Rx/drop frame counters.
module hdlc_frame_ctrl
   import hdlc_ctrl_pkg::*;
#(
   parameter logic [2:0] ADDR_TX_SC  = DEF_ADDR_TX_SC,
   parameter logic [2:0] ADDR_TX_BUF = DEF_ADDR_TX_BUF,
   parameter logic [2:0] ADDR_RX_SC  = DEF_ADDR_RX_SC,
   parameter logic [2:0] ADDR_RX_BUF = DEF_ADDR_RX_BUF,
   parameter logic [2:0] ADDR_RX_LEN = DEF_ADDR_RX_LEN,
   parameter int TX_EN_BIT   = DEF_TX_EN_BIT,
   parameter int RX_DROP_BIT = DEF_RX_DROP_BIT,
   parameter int MAX_FRAME   = DEF_MAX_FRAME,
   parameter int RD_LAT      = DEF_RD_LAT
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [7:0] s_tx_data,
   input  logic       s_tx_valid,
   input  logic       s_tx_last,
   output logic       s_tx_ready,
   output logic [7:0] m_rx_data,
   output logic       m_rx_valid,
   output logic       m_rx_last,
   input  logic       m_rx_ready,
   output logic [2:0] bus_addr,
   output logic       bus_we,
   output logic       bus_re,
   output logic [7:0] bus_wdata,
   input  logic [7:0] bus_rdata,
   input  logic       Tx_Done,
   input  logic       Rx_Ready,
   output logic       busy,
   output logic       tx_trunc
`ifdef HDLC_FRAME_CTRL_STATS_EN
   ,
   output logic [15:0] tx_frame_cnt,
   output logic [15:0] rx_frame_cnt,
   output logic [15:0] rx_drop_cnt
`endif
);

   state_t r_state, w_state_nxt;

   logic [7:0]        r_cnt, w_cnt_nxt;
   logic [7:0]        r_len, w_len_nxt;
   logic              r_first, w_first_nxt;
   logic [RD_LAT-1:0] r_rd_sr;
   logic              w_rd_valid;
   logic              w_last;

   logic [2:0] r_bus_addr, w_addr;
   logic       r_bus_we, w_we;
   logic       r_bus_re, w_re;
   logic [7:0] r_bus_wdata, w_wdata;
   logic       r_tx_trunc, w_trunc;
   logic [7:0] r_rx_data, w_rx_data;

   // Read data is valid RD_LAT cycles after the strobe leaves the block.
   assign w_rd_valid = r_rd_sr[RD_LAT-1];
   assign w_last     = (r_cnt == r_len);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_len_nxt   = r_len;
      w_first_nxt = 1'b0;
      w_addr      = r_bus_addr;
      w_we        = 1'b0;
      w_re        = 1'b0;
      w_wdata     = r_bus_wdata;
      w_trunc     = 1'b0;
      w_rx_data   = r_rx_data;
      unique case (r_state)
         S_IDLE: begin
            w_cnt_nxt = 8'd0;
            // Let a pending drop write settle Rx_Ready first.
            if (!r_bus_we && !r_bus_re) begin
               if (Rx_Ready) begin
                  w_state_nxt = S_RX_LEN;
               end else if (s_tx_valid) begin
                  w_state_nxt = S_TX_LOAD;
               end
            end
         end
         S_TX_LOAD: begin
            if (s_tx_valid) begin
               w_we      = 1'b1;
               w_addr    = ADDR_TX_BUF;
               w_wdata   = s_tx_data;
               w_cnt_nxt = r_cnt + 8'd1;
               if (s_tx_last || r_cnt == 8'(MAX_FRAME - 1)) begin
                  w_state_nxt = S_TX_START;
                  w_trunc     = !s_tx_last;
               end
            end
         end
         S_TX_START: begin
            w_we        = 1'b1;
            w_addr      = ADDR_TX_SC;
            w_wdata     = 8'(1 << TX_EN_BIT);
            w_first_nxt = 1'b1;
            w_state_nxt = S_TX_WAIT;
         end
         S_TX_WAIT: begin
            if (!r_first && Tx_Done) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RX_LEN: begin
            w_re        = 1'b1;
            w_addr      = ADDR_RX_LEN;
            w_cnt_nxt   = 8'd0;
            w_state_nxt = S_RX_LEN_WAIT;
         end
         S_RX_LEN_WAIT: begin
            if (w_rd_valid) begin
               w_len_nxt = bus_rdata;
               if (bus_rdata == 8'd0 || bus_rdata > 8'(MAX_FRAME)) begin
                  w_state_nxt = S_RX_DROP;
               end else begin
                  w_state_nxt = S_RX_RD;
               end
            end
         end
         S_RX_RD: begin
            w_re        = 1'b1;
            w_addr      = ADDR_RX_BUF;
            w_state_nxt = S_RX_RD_WAIT;
         end
         S_RX_RD_WAIT: begin
            if (w_rd_valid) begin
               w_rx_data   = bus_rdata;
               w_cnt_nxt   = r_cnt + 8'd1;
               w_state_nxt = S_RX_OUT;
            end
         end
         S_RX_OUT: begin
            if (m_rx_ready) begin
               w_state_nxt = w_last ? S_IDLE : S_RX_RD;
            end
         end
         S_RX_DROP: begin
            w_we        = 1'b1;
            w_addr      = ADDR_RX_SC;
            w_wdata     = 8'(1 << RX_DROP_BIT);
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 8'd0;
         r_len       <= 8'd0;
         r_first     <= 1'b0;
         r_rd_sr     <= '0;
         r_bus_addr  <= 3'd0;
         r_bus_we    <= 1'b0;
         r_bus_re    <= 1'b0;
         r_bus_wdata <= 8'd0;
         r_tx_trunc  <= 1'b0;
         r_rx_data   <= 8'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_len       <= w_len_nxt;
         r_first     <= w_first_nxt;
         r_rd_sr     <= (r_rd_sr << 1) | RD_LAT'(r_bus_re);
         r_bus_addr  <= w_addr;
         r_bus_we    <= w_we;
         r_bus_re    <= w_re;
         r_bus_wdata <= w_wdata;
         r_tx_trunc  <= w_trunc;
         r_rx_data   <= w_rx_data;
      end
   end

   assign s_tx_ready = (r_state == S_TX_LOAD);
   assign m_rx_valid = (r_state == S_RX_OUT);
   assign m_rx_last  = m_rx_valid && w_last;
   assign m_rx_data  = r_rx_data;
   assign bus_addr   = r_bus_addr;
   assign bus_we     = r_bus_we;
   assign bus_re     = r_bus_re;
   assign bus_wdata  = r_bus_wdata;
   assign busy       = (r_state != S_IDLE);
   assign tx_trunc   = r_tx_trunc;

`ifdef HDLC_FRAME_CTRL_STATS_EN
   logic [15:0] r_tx_frm, r_rx_frm, r_rx_drop;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_tx_frm  <= 16'd0;
         r_rx_frm  <= 16'd0;
         r_rx_drop <= 16'd0;
      end else begin
         if (r_state == S_TX_START) begin
            r_tx_frm <= r_tx_frm + 16'd1;
         end
         if (m_rx_valid && m_rx_ready && w_last) begin
            r_rx_frm <= r_rx_frm + 16'd1;
         end
         if (r_state == S_RX_DROP) begin
            r_rx_drop <= r_rx_drop + 16'd1;
         end
      end
   end

   assign tx_frame_cnt = r_tx_frm;
   assign rx_frame_cnt = r_rx_frm;
   assign rx_drop_cnt  = r_rx_drop;
`endif

endmodule

// File: tb/tb_hdlc_frame_ctrl.sv
// Bench for hdlc_frame_ctrl: core register model, frame-level reference
// model, directed frames then randomized Tx/Rx traffic.
module tb_hdlc_frame_ctrl;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic [7:0] s_tx_data = 8'd0;
   logic       s_tx_valid = 1'b0;
   logic       s_tx_last = 1'b0;
   logic       s_tx_ready;
   logic [7:0] m_rx_data;
   logic       m_rx_valid;
   logic       m_rx_last;
   logic       m_rx_ready = 1'b0;
   logic [2:0] bus_addr;
   logic       bus_we;
   logic       bus_re;
   logic [7:0] bus_wdata;
   logic [7:0] bus_rdata = 8'd0;
   logic       Tx_Done = 1'b1;
   logic       Rx_Ready = 1'b0;
   logic       busy;
   logic       tx_trunc;
`ifdef HDLC_FRAME_CTRL_STATS_EN
   logic [15:0] tx_frame_cnt, rx_frame_cnt, rx_drop_cnt;
`endif

   hdlc_frame_ctrl dut (
      .Clk(Clk), .Rst(Rst),
      .s_tx_data(s_tx_data), .s_tx_valid(s_tx_valid),
      .s_tx_last(s_tx_last), .s_tx_ready(s_tx_ready),
      .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid),
      .m_rx_last(m_rx_last), .m_rx_ready(m_rx_ready),
      .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .Tx_Done(Tx_Done), .Rx_Ready(Rx_Ready),
      .busy(busy), .tx_trunc(tx_trunc)
`ifdef HDLC_FRAME_CTRL_STATS_EN
      , .tx_frame_cnt(tx_frame_cnt), .rx_frame_cnt(rx_frame_cnt),
      .rx_drop_cnt(rx_drop_cnt)
`endif
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Reference model state: expected bus traffic and output stream.
   logic [8:0]  tx_stim[$];
   logic [11:0] exp_tx[$];
   logic [8:0]  exp_rx[$];
   logic [2:0]  exp_rd[$];
   int          exp_drop = 0;
   int          tx_n = 0;
   int          mdl_tx = 0, mdl_rx = 0, mdl_drop = 0;

   // Core model state.
   logic [7:0] rxf_len[$];
   logic [7:0] rxf_data[$];
   logic [7:0] cur_bytes[$];
   logic [7:0] cur_len = 8'd0;
   int         gap = 0;
   int         tx_busy = 0;
   bit         rx_go = 1'b1;

   // Observation logs for directed literal checks.
   logic [11:0] wlog[$];
   logic [2:0]  rlog[$];
   logic [8:0]  olog[$];
   int          cyc = 0;
   int          first_txbuf_cyc = -1;
   int          last_rx_cyc = -1;
   bit          chk_en = 1'b0;
   bit          rdy_mode = 1'b0;

   task automatic push_tx(input logic [7:0] b, input bit last);
      tx_stim.push_back({last, b});
      tx_n++;
      exp_tx.push_back({(tx_n == 126) && !last, 3'd1, b});
      if (last || tx_n == 126) begin
         exp_tx.push_back({1'b0, 3'd0, 8'h02});
         tx_n = 0;
         mdl_tx++;
      end
   endtask

   task automatic add_rx(input int len, input bit seq);
      logic [7:0] b;
      rxf_len.push_back(8'(len));
      exp_rd.push_back(3'd4);
      if (len >= 1 && len <= 126) begin
         for (int i = 0; i < len; i++) begin
            b = seq ? 8'(i + 1) : 8'($urandom);
            rxf_data.push_back(b);
            exp_rx.push_back({i == len - 1, b});
            exp_rd.push_back(3'd3);
         end
         mdl_rx++;
      end else begin
         exp_drop++;
         mdl_drop++;
      end
   endtask

   task automatic tx_run(input bit gaps);
      logic [8:0] it;
      bit         acc;
      int         tmo;
      while (tx_stim.size() > 0) begin
         it = tx_stim.pop_front();
         if (gaps && $urandom_range(0, 3) == 0) begin
            s_tx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
               @(posedge Clk); #1;
            end
         end
         s_tx_data  = it[7:0];
         s_tx_last  = it[8];
         s_tx_valid = 1'b1;
         tmo = 0;
         do begin
            @(negedge Clk);
            acc = s_tx_ready;
            tmo++;
            @(posedge Clk); #1;
         end while (!acc && tmo < 5000);
         chk("tx_accept", acc, 1);
         if (!acc) break;
      end
      s_tx_valid = 1'b0;
      s_tx_last  = 1'b0;
   endtask

   task automatic drain(input string nm);
      bit ok = 1'b0;
      for (int t = 0; t < 20000 && !ok; t++) begin
         @(negedge Clk);
         ok = exp_tx.size() == 0 && exp_rx.size() == 0 &&
              exp_rd.size() == 0 && exp_drop == 0 &&
              rxf_len.size() == 0 && tx_stim.size() == 0 &&
              !Rx_Ready && !busy;
      end
      chk(nm, ok, 1);
   endtask

   task automatic clr_logs();
      wlog.delete();
      rlog.delete();
      olog.delete();
      first_txbuf_cyc = -1;
      last_rx_cyc = -1;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_s_tx_ready"}, s_tx_ready, 0);
      chk({nm, "_m_rx_valid"}, m_rx_valid, 0);
      chk({nm, "_m_rx_last"}, m_rx_last, 0);
      chk({nm, "_m_rx_data"}, m_rx_data, 0);
      chk({nm, "_bus_addr"}, bus_addr, 0);
      chk({nm, "_bus_we"}, bus_we, 0);
      chk({nm, "_bus_re"}, bus_re, 0);
      chk({nm, "_bus_wdata"}, bus_wdata, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_tx_trunc"}, tx_trunc, 0);
   endtask

   // HDLC core register model: reacts to strobes seen during a cycle.
   always begin
      logic       n_done, n_rr;
      logic [7:0] n_rd;
      @(negedge Clk);
      n_done = Tx_Done;
      n_rr   = Rx_Ready;
      n_rd   = bus_rdata;
      if (Rst) begin
         if (bus_we && bus_addr == 3'd0) begin
            n_done  = 1'b0;
            tx_busy = $urandom_range(1, 8);
         end else if (tx_busy > 0) begin
            tx_busy--;
            if (tx_busy == 0) n_done = 1'b1;
         end
         if (bus_re && bus_addr == 3'd4) n_rd = cur_len;
         if (bus_re && bus_addr == 3'd3) begin
            n_rd = (cur_bytes.size() > 0) ? cur_bytes.pop_front() : 8'hEE;
            if (cur_bytes.size() == 0) begin
               n_rr = 1'b0;
               gap  = $urandom_range(1, 4);
            end
         end
         if (bus_we && bus_addr == 3'd2) begin
            n_rr = 1'b0;
            cur_bytes.delete();
            gap  = $urandom_range(1, 4);
         end
         if (!n_rr && !Rx_Ready && rx_go && gap == 0 &&
             rxf_len.size() > 0) begin
            cur_len = rxf_len.pop_front();
            cur_bytes.delete();
            if (cur_len >= 8'd1 && cur_len <= 8'd126) begin
               repeat (int'(cur_len)) cur_bytes.push_back(rxf_data.pop_front());
            end
            n_rr = 1'b1;
         end else if (gap > 0 && !Rx_Ready) begin
            gap--;
         end
      end
      @(posedge Clk); #1;
      Tx_Done   = n_done;
      Rx_Ready  = n_rr;
      bus_rdata = n_rd;
   end

   always @(posedge Clk) begin
      #1;
      if (rdy_mode) m_rx_ready = ($urandom_range(0, 3) != 0);
   end

   // Compare process: every cycle checks the bus and stream against the model.
   bit         prev_stall = 1'b0, prev_busy = 1'b0, prev_done = 1'b1;
   bit         in_tx = 1'b0, saw_low = 1'b0;
   logic [8:0] prev_o = 9'd0;

   always @(negedge Clk) begin
      cyc++;
      if (Rst && chk_en) begin
         chk("we_re_excl", bus_we & bus_re, 0);
         if (bus_we) begin
            if (bus_addr <= 3'd1) begin
               wlog.push_back({tx_trunc, bus_addr, bus_wdata});
               if (bus_addr == 3'd1 && first_txbuf_cyc < 0) first_txbuf_cyc = cyc;
               if (bus_addr == 3'd0) begin
                  in_tx = 1'b1;
                  saw_low = 1'b0;
               end
               chk("tx_wr_avail", exp_tx.size() != 0, 1);
               if (exp_tx.size() != 0)
                  chk("tx_wr", {tx_trunc, bus_addr, bus_wdata}, exp_tx.pop_front());
            end else if (bus_addr == 3'd2) begin
               wlog.push_back({tx_trunc, bus_addr, bus_wdata});
               chk("drop_wdata", bus_wdata, 8'h02);
               chk("drop_avail", exp_drop > 0, 1);
               if (exp_drop > 0) exp_drop--;
            end else begin
               chk("wr_addr", bus_addr, 3'd2);
            end
         end
         if (!(bus_we && bus_addr <= 3'd1)) chk("trunc_quiet", tx_trunc, 0);
         if (bus_re) begin
            rlog.push_back(bus_addr);
            chk("rd_avail", exp_rd.size() != 0, 1);
            if (exp_rd.size() != 0) chk("rd_addr", bus_addr, exp_rd.pop_front());
         end
         if (prev_stall)
            chk("rx_hold", {m_rx_valid, m_rx_last, m_rx_data}, {1'b1, prev_o});
         if (m_rx_valid && m_rx_ready) begin
            olog.push_back({m_rx_last, m_rx_data});
            if (m_rx_last) last_rx_cyc = cyc;
            chk("rx_avail", exp_rx.size() != 0, 1);
            if (exp_rx.size() != 0) chk("rx_out", {m_rx_last, m_rx_data}, exp_rx.pop_front());
         end
         prev_stall = m_rx_valid && !m_rx_ready;
         prev_o     = {m_rx_last, m_rx_data};
         if (in_tx && !Tx_Done) saw_low = 1'b1;
         if (prev_busy && !busy && in_tx) begin
            chk("txdone_low_seen", saw_low, 1);
            chk("txdone_before_idle", prev_done, 1);
            in_tx = 1'b0;
         end
         prev_busy = busy;
         prev_done = Tx_Done;
      end else begin
         prev_stall = 1'b0;
         prev_busy  = 1'b0;
         in_tx      = 1'b0;
      end
   end

   int na1, na0, ntr, tmo;

   initial begin
      #2 Rst = 1'b0;
      #1 chk_zero("reset");
      repeat (3) @(posedge Clk);
      #1 Rst = 1'b1;
      m_rx_ready = 1'b1;
      chk_en = 1'b1;

      // Three-byte Tx frame.
      clr_logs();
      push_tx(8'hA5, 0);
      push_tx(8'h5A, 0);
      push_tx(8'hFF, 1);
      tx_run(0);
      drain("t1_drain");
      chk("t1_nwr", wlog.size(), 4);
      chk("t1_w0", wlog[0], 12'h1A5);
      chk("t1_w1", wlog[1], 12'h15A);
      chk("t1_w2", wlog[2], 12'h1FF);
      chk("t1_w3", wlog[3], 12'h002);
      chk("t1_nrd", rlog.size(), 0);

      // Rx frame of 4 with a 5-cycle downstream stall.
      clr_logs();
      m_rx_ready = 1'b0;
      add_rx(4, 1);
      tmo = 0;
      do begin
         @(negedge Clk);
         tmo++;
      end while (!m_rx_valid && tmo < 200);
      chk("t2_valid_seen", m_rx_valid, 1);
      repeat (5) @(negedge Clk);
      @(posedge Clk); #1 m_rx_ready = 1'b1;
      drain("t2_drain");
      chk("t2_nrd", rlog.size(), 5);
      chk("t2_r0", rlog[0], 3'd4);
      chk("t2_r4", rlog[4], 3'd3);
      chk("t2_nout", olog.size(), 4);
      chk("t2_o0", olog[0], 9'h001);
      chk("t2_o2", olog[2], 9'h003);
      chk("t2_o3", olog[3], 9'h104);

      // Zero-length Rx frame is dropped.
      clr_logs();
      add_rx(0, 0);
      drain("t3_drain");
      chk("t3_nrd", rlog.size(), 1);
      chk("t3_r0", rlog[0], 3'd4);
      chk("t3_nwr", wlog.size(), 1);
      chk("t3_w0", wlog[0], 12'h202);
      chk("t3_nout", olog.size(), 0);

      // Rx_Ready and s_tx_valid in the same cycle.
      clr_logs();
      rx_go = 1'b0;
      add_rx(2, 0);
      push_tx(8'h77, 0);
      push_tx(8'h88, 1);
      @(negedge Clk);
      #2 rx_go = 1'b1;
      @(negedge Clk);
      @(posedge Clk); #1;
      tx_run(0);
      drain("t4_drain");
      chk("t4_rx_done", last_rx_cyc >= 0, 1);
      chk("t4_rx_first", first_txbuf_cyc > last_rx_cyc, 1);

      // 130-byte stream: cut at 126, rest forms a second frame.
      clr_logs();
      for (int i = 0; i < 130; i++) push_tx(8'(i + 8'h40), i == 129);
      tx_run(0);
      drain("t5_drain");
      na1 = 0; na0 = 0; ntr = 0;
      foreach (wlog[i]) begin
         if (wlog[i][10:8] == 3'd1) na1++;
         if (wlog[i][10:8] == 3'd0) na0++;
         if (wlog[i][11]) ntr++;
      end
      chk("t5_nbuf", na1, 130);
      chk("t5_nstart", na0, 2);
      chk("t5_ntrunc", ntr, 1);
      chk("t5_trunc_at_126", wlog[125], 12'h9BD);
      chk("t5_start1", wlog[126], 12'h002);
      chk("t5_f2_first", wlog[127], 12'h1BE);

      // Asynchronous reset in the middle of TX_LOAD.
      chk_en = 1'b0;
      @(posedge Clk); #1;
      s_tx_data = 8'h11;
      s_tx_last = 1'b0;
      s_tx_valid = 1'b1;
      repeat (4) begin
         @(posedge Clk); #1;
         s_tx_data = s_tx_data + 8'd1;
      end
      chk("t6_loading", s_tx_ready, 1);
      chk("t6_writing", bus_we, 1);
      #2 Rst = 1'b0;
      #1 chk_zero("t6_rst");
      s_tx_valid = 1'b0;
      exp_tx.delete();
      tx_n = 0;
      mdl_tx = 0; mdl_rx = 0; mdl_drop = 0;
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b1;
      @(negedge Clk);
      chk("t6_busy_after", busy, 0);
      clr_logs();
      chk_en = 1'b1;
      push_tx(8'h31, 0);
      push_tx(8'h32, 0);
      push_tx(8'h33, 1);
      tx_run(0);
      drain("t6_drain");
      chk("t6_nwr", wlog.size(), 4);
      chk("t6_w0", wlog[0], 12'h131);
      chk("t6_w3", wlog[3], 12'h002);

      // Randomized mixed traffic.
      rdy_mode = 1'b1;
      for (int k = 0; k < 40; k++) begin
         int r, len;
         r = $urandom_range(0, 9);
         if (r < 4) begin
            len = (r == 0) ? $urandom_range(120, 135) : $urandom_range(1, 12);
            for (int i = 0; i < len; i++) push_tx(8'($urandom), i == len - 1);
         end else begin
            len = (r == 9) ? $urandom_range(127, 255) :
                  (r == 8) ? 0 : $urandom_range(1, 10);
            add_rx(len, 0);
         end
      end
      tx_run(1);
      drain("rand_drain");
      rdy_mode = 1'b0;

`ifdef HDLC_FRAME_CTRL_STATS_EN
      chk("stat_tx", tx_frame_cnt, mdl_tx);
      chk("stat_rx", rx_frame_cnt, mdl_rx);
      chk("stat_drop", rx_drop_cnt, mdl_drop);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
